// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: data-path widths,
//            RV32I load/store funct3 codes, memory addressable-unit codes,
//            FSM state encoding and request legality/alignment helpers.
// Revision : 1.0 - initial release
// ============================================================================

// Widths shared with the data memory; the system may predefine them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

// Memory addressable-unit codes, shared with the data memory.
`ifndef BYTE_MEMORY_MODE
`define BYTE_MEMORY_MODE 2'b00
`endif
`ifndef HALFWORD_MEMORY_MODE
`define HALFWORD_MEMORY_MODE 2'b01
`endif
`ifndef WORD_MEMORY_MODE
`define WORD_MEMORY_MODE 2'b10
`endif

package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MODE_BYTE     = `BYTE_MEMORY_MODE;
    localparam logic [1:0] MODE_HALFWORD = `HALFWORD_MEMORY_MODE;
    localparam logic [1:0] MODE_WORD     = `WORD_MEMORY_MODE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } lsu_state_e;

    // Stores have no unsigned variants, so only the three base codes apply.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // Natural alignment, keyed on the access size in funct3[1:0].
    function automatic logic addr_aligned(input logic [1:0] unit, input logic [1:0] lsb);
        logic ok;
        ok = 1'b1;
        case (unit)
            MODE_HALFWORD: ok = (lsb[0] == 1'b0);
            MODE_WORD:     ok = (lsb == 2'b00);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational load-data extension. Selects the low byte,
//            halfword or full word of the memory read data and sign- or
//            zero-extends it according to the load funct3.
// Ports    : funct3_i  - load funct3 (LB/LH/LW/LBU/LHU)
//            word_i    - right-aligned memory read data
//            word_o    - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    output logic [WORD_WIDTH-1:0] word_o
);

    always_comb begin
        word_o = word_i;
        case (funct3_i)
            F3_LB:   word_o = {{(WORD_WIDTH-8){word_i[7]}}, word_i[7:0]};
            F3_LBU:  word_o = {{(WORD_WIDTH-8){1'b0}}, word_i[7:0]};
            F3_LH:   word_o = {{(WORD_WIDTH-16){word_i[15]}}, word_i[15:0]};
            F3_LHU:  word_o = {{(WORD_WIDTH-16){1'b0}}, word_i[15:0]};
            default: word_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Bridges the core datapath to a synchronous byte-addressed data
//            memory. Accepts one load/store at a time, rejects illegal
//            funct3 and misaligned addresses without touching memory, drives
//            the memory enables/unit/address/data from the registered
//            request, and returns an extended, registered load response.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req_valid/req_ready           - request handshake
//            req_we/funct3/addr/wdata      - request fields
//            resp_valid/resp_ready         - response handshake
//            resp_rdata/resp_err           - response payload
//            mem_read/mem_write            - memory enables (never both)
//            mem_addr_unit/address/wdata   - memory access fields
//            mem_rdata                     - read data, one cycle after read
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int WORD_WIDTH = `WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_addr_unit,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;

    logic                  w_hs;
    logic                  w_req_err;
    logic [WORD_WIDTH-1:0] w_ext;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign w_hs      = req_valid && req_ready;
    assign w_req_err = !f3_legal(req_we, req_funct3) ||
                       !addr_aligned(req_funct3[1:0], req_addr[1:0]);

    load_extend #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_load_extend (
        .funct3_i (funct3_q),
        .word_i   (mem_rdata),
        .word_o   (w_ext)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_hs) begin
                    // Clearing rdata here covers both the store and error paths.
                    rdata_d = '0;
                    err_d   = w_req_err;
                    if (w_req_err) begin
                        state_d = S_RESP;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_d = w_ext;
                state_d = S_RESP;
                valid_d = 1'b1;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            if (w_hs) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Enables are gated with rst so a reset landing in ACCESS cannot
    // corrupt memory.
    assign mem_read      = (state_q == S_ACCESS) && !we_q && !rst;
    assign mem_write     = (state_q == S_ACCESS) &&  we_q && !rst;
    assign mem_addr_unit = funct3_q[1:0];
    assign mem_address   = addr_q;
    assign mem_wdata     = wdata_q;

    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a byte-array data
//            memory model, table-driven request vectors, a response
//            scoreboard and hand-written back-pressure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int AW = 16;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [WW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [WW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_addr_unit;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int acc_total = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
        int          lat;
    } vec_t;
    vec_t vt[$];

    load_store_unit #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr_unit (mem_addr_unit),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: returns four bytes starting at the address.
    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma = mem_address[7:0];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_read || mem_write) acc_total <= acc_total + 1;
        if (mem_write) begin
            case (mem_addr_unit)
                2'b00: mem[ma] <= mem_wdata[7:0];
                2'b01: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[8'(ma + 1)] <= mem_wdata[15:8];
                end
                2'b10: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[8'(ma + 1)] <= mem_wdata[15:8];
                    mem[8'(ma + 2)] <= mem_wdata[23:16];
                    mem[8'(ma + 3)] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
        if (mem_read)
            mem_rdata <= {mem[8'(ma + 3)], mem[8'(ma + 2)], mem[8'(ma + 1)], mem[ma]};
    end

    // Per-cycle invariants.
    always @(negedge clk) begin
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL rw_exclusive: mem_read=%0b mem_write=%0b, required not both", mem_read, mem_write);
        end
        if (rst && (mem_read || mem_write)) begin
            errors++;
            $display("FAIL access_in_reset: mem_read=%0b mem_write=%0b, required 0", mem_read, mem_write);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat);
        int  n;
        int  base;
        sb_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        sb.push_back('{er, ee});
        base = acc_total;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_latency", 32'(n), 32'(lat));
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
        end else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
        end
        chk("mem_accesses", 32'(acc_total - base), ee ? 32'd0 : 32'd1);
    endtask

    // With resp_ready high the response is consumed at the next edge.
    task automatic finish_resp();
        @(posedge clk); #1;
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // Vectors: we, f3, addr, wdata, expected rdata, expected err, latency.
        vt.push_back('{1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2});
        vt.push_back('{1'b0, 3'b010, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3});
        vt.push_back('{1'b0, 3'b000, 16'h0010, 32'h0,        32'hFFFFFFEF, 1'b0, 3});
        vt.push_back('{1'b0, 3'b100, 16'h0010, 32'h0,        32'h000000EF, 1'b0, 3});
        vt.push_back('{1'b0, 3'b001, 16'h0012, 32'h0,        32'hFFFFDEAD, 1'b0, 3});
        vt.push_back('{1'b0, 3'b101, 16'h0012, 32'h0,        32'h0000DEAD, 1'b0, 3});
        vt.push_back('{1'b0, 3'b000, 16'h0013, 32'h0,        32'hFFFFFFDE, 1'b0, 3});
        vt.push_back('{1'b0, 3'b001, 16'h0011, 32'h0,        32'h00000000, 1'b1, 1});
        vt.push_back('{1'b0, 3'b010, 16'h0012, 32'h0,        32'h00000000, 1'b1, 1});
        vt.push_back('{1'b0, 3'b011, 16'h0010, 32'h0,        32'h00000000, 1'b1, 1});
        vt.push_back('{1'b0, 3'b110, 16'h0010, 32'h0,        32'h00000000, 1'b1, 1});
        vt.push_back('{1'b1, 3'b100, 16'h0020, 32'h11111111, 32'h00000000, 1'b1, 1});
        vt.push_back('{1'b1, 3'b001, 16'h0015, 32'h22222222, 32'h00000000, 1'b1, 1});
        vt.push_back('{1'b1, 3'b001, 16'h0014, 32'h12348001, 32'h00000000, 1'b0, 2});
        vt.push_back('{1'b0, 3'b001, 16'h0014, 32'h0,        32'hFFFF8001, 1'b0, 3});
        vt.push_back('{1'b0, 3'b101, 16'h0014, 32'h0,        32'h00008001, 1'b0, 3});
        vt.push_back('{1'b0, 3'b010, 16'h0014, 32'h0,        32'h00008001, 1'b0, 3});
        vt.push_back('{1'b1, 3'b000, 16'h0020, 32'hFFFFFFA5, 32'h00000000, 1'b0, 2});
        vt.push_back('{1'b0, 3'b000, 16'h0020, 32'h0,        32'hFFFFFFA5, 1'b0, 3});
        vt.push_back('{1'b0, 3'b010, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_unit", 32'(mem_addr_unit), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, vt[i].er, vt[i].ee, vt[i].lat);
            finish_resp();
        end

        // Back-pressure: response must hold steady with no new access.
        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        base = acc_total;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        chk("hold_no_access", 32'(acc_total - base), 32'd0);
        resp_ready = 1'b1;
        finish_resp();

        // Reset landing in the ACCESS cycle of SB 0x55 -> 0x20.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 16'h0020;
        req_wdata  = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("access_write_pre_rst", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("access_write_gated", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_byte", 32'(mem[8'h20]), 32'h000000A5);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_rdata", resp_rdata, 32'd0);
        chk("rst_mid_err", 32'(resp_err), 32'd0);
        chk("rst_mid_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mid_unit", 32'(mem_addr_unit), 32'd0);
        chk("rst_mid_address", 32'(mem_address), 32'd0);
        chk("rst_mid_wdata", mem_wdata, 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 3'b100, 16'h0020, 32'h0, 32'h000000A5, 1'b0, 3);
        finish_resp();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
